// File: rtl/decision_making_n_pkg.sv
// decision_pkg: shared FSM state type and sizing helpers for decision_making_n.
//   state_t : IDLE, MAC, CMP, DONE
//   acc_w   : accumulator width, 2*width + clog2(n_feat+1)
//   addr_w  : weight/bias table address width
//   lat     : start-to-done latency in clock edges
package decision_pkg;
    typedef enum logic [1:0] {IDLE, MAC, CMP, DONE} state_t;

    function automatic int acc_w(input int width, input int n_feat);
        return 2 * width + $clog2(n_feat + 1);
    endfunction

    function automatic int addr_w(input int n_class, input int n_feat);
        return $clog2(n_class * (n_feat + 1));
    endfunction

    function automatic int lat(input int n_class, input int n_feat);
        return n_class * (n_feat + 1) + 1;
    endfunction
endpackage

// File: rtl/decision_making_n_if.sv
// decision_making_n_if: start/feature, table-write and result signals of the classifier.
//   master : drives start_i, feat_i, w_we_i, w_addr_i, w_data_i
//   slave  : drives busy_o, done_o, class_o, onehot_o (and score_o with DECISION_SCORE_OUT_EN)
interface decision_making_n_if #(
    parameter int WIDTH   = 32,
    parameter int N_FEAT  = 4,
    parameter int N_CLASS = 3
) ();
    import decision_pkg::*;
    logic                                        start_i;
    logic [N_FEAT*WIDTH-1:0]                     feat_i;
    logic                                        w_we_i;
    logic [addr_w(N_CLASS, N_FEAT)-1:0]          w_addr_i;
    logic [WIDTH-1:0]                            w_data_i;
    logic                                        busy_o;
    logic                                        done_o;
    logic [$clog2(N_CLASS)-1:0]                  class_o;
    logic [N_CLASS-1:0]                          onehot_o;
`ifdef DECISION_SCORE_OUT_EN
    logic signed [acc_w(WIDTH, N_FEAT)-1:0]      score_o;
    modport master (output start_i, feat_i, w_we_i, w_addr_i, w_data_i,
                    input busy_o, done_o, class_o, onehot_o, score_o);
    modport slave  (input start_i, feat_i, w_we_i, w_addr_i, w_data_i,
                    output busy_o, done_o, class_o, onehot_o, score_o);
`else
    modport master (output start_i, feat_i, w_we_i, w_addr_i, w_data_i,
                    input busy_o, done_o, class_o, onehot_o);
    modport slave  (input start_i, feat_i, w_we_i, w_addr_i, w_data_i,
                    output busy_o, done_o, class_o, onehot_o);
`endif
endinterface

// File: rtl/decision_making_n_mac.sv
// decision_mac: signed multiply, arithmetic right shift by SHIFT, accumulate.
//   clk, rst : clock, async active-high reset
//   clr      : zero the accumulator (wins over en)
//   en       : add (a*b)>>>SHIFT into acc
//   a, b     : signed operands; acc : signed running sum
module decision_mac #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 4,
    parameter int AW    = 67
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [AW-1:0]    acc
);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    assign prod    = a * b;
    assign prod_sh = prod >>> SHIFT;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + AW'(prod_sh);
endmodule

// File: rtl/decision_making_n.sv
// decision_making_n: linear classifier with runtime weight/bias table and argmax output.
//   clk, rst : clock, async active-high reset
//   bus      : decision_making_n_if.slave (start/features, table writes, busy/done/class/onehot)
//   Optional macro DECISION_SCORE_OUT_EN adds bus.score_o, the winning score.
module decision_making_n #(
    parameter int WIDTH   = 32,
    parameter int SHIFT   = 4,
    parameter int N_FEAT  = 4,
    parameter int N_CLASS = 3
) (
    input logic                clk,
    input logic                rst,
    decision_making_n_if.slave bus
);
    import decision_pkg::*;
    localparam int AW    = acc_w(WIDTH, N_FEAT);
    localparam int ADW   = addr_w(N_CLASS, N_FEAT);
    localparam int CW    = $clog2(N_CLASS);
    localparam int JW    = $clog2(N_FEAT + 1);
    localparam int DEPTH = N_CLASS * (N_FEAT + 1);

    state_t                  state, nxt;
    logic [CW-1:0]           k, idx;
    logic [JW-1:0]           j;
    logic [N_FEAT*WIDTH-1:0] feat_q;
    logic signed [WIDTH-1:0] tbl [DEPTH];
    logic signed [AW-1:0]    acc, best, score;
    logic [ADW-1:0]          w_addr, b_addr;
    logic                    last_j, last_k, take;

    assign last_j = j == JW'(N_FEAT - 1);
    assign last_k = k == CW'(N_CLASS - 1);
    assign w_addr = ADW'(k * (N_FEAT + 1) + j);
    assign b_addr = ADW'(k * (N_FEAT + 1) + N_FEAT);
    assign score  = acc + AW'(tbl[b_addr]);
    assign take   = state == IDLE && bus.start_i;
    assign bus.busy_o = state != IDLE;

    // acc is cleared on start and between classes so each class sums from zero
    decision_mac #(.WIDTH(WIDTH), .SHIFT(SHIFT), .AW(AW)) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(take || (state == CMP && !last_k)),
        .en(state == MAC),
        .a(tbl[w_addr]),
        .b($signed(feat_q[j*WIDTH +: WIDTH])),
        .acc(acc)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start_i ? MAC : IDLE;
            MAC:     nxt = last_j ? CMP : MAC;
            CMP:     nxt = last_k ? DONE : MAC;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            k            <= '0;
            j            <= '0;
            idx          <= '0;
            best         <= '0;
            feat_q       <= '0;
            bus.done_o   <= 1'b0;
            bus.class_o  <= '0;
            bus.onehot_o <= '0;
`ifdef DECISION_SCORE_OUT_EN
            bus.score_o  <= '0;
`endif
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
        end else begin
            bus.done_o <= state == DONE;
            if (take) begin
                feat_q <= bus.feat_i;
                k      <= '0;
                j      <= '0;
            end
            if (state == MAC)
                j <= last_j ? '0 : j + 1'b1;
            // strict > keeps the lowest index on ties
            if (state == CMP) begin
                if (k == '0 || score > best) begin
                    best <= score;
                    idx  <= k;
                end
                if (!last_k)
                    k <= k + 1'b1;
            end
            if (state == DONE) begin
                bus.class_o  <= idx;
                bus.onehot_o <= N_CLASS'(1) << idx;
`ifdef DECISION_SCORE_OUT_EN
                bus.score_o  <= best;
`endif
            end
            // table only changes while idle; out-of-range addresses are dropped
            if (bus.w_we_i && state == IDLE && 32'(bus.w_addr_i) < DEPTH)
                tbl[bus.w_addr_i] <= bus.w_data_i;
        end
endmodule
